// File: rtl/axi_pkg.sv
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WBEAT,
    WRESP,
    RBEAT
  } state_t;

  function automatic logic [63:0] wrap_mask(input logic [2:0] size, input logic [7:0] len);
    return (({56'd0, len} + 64'd1) << size) - 64'd1;
  endfunction

  function automatic logic [63:0] next_beat_addr(
    input logic [63:0] addr,
    input logic [2:0]  size,
    input logic [7:0]  len,
    input logic [1:0]  burst
  );
    logic [63:0] inc;
    logic [63:0] mask;
    logic [63:0] result;
    inc  = addr + (64'd1 << size);
    mask = wrap_mask(size, len);
    case (burst)
      BURST_INCR: result = inc;
      BURST_WRAP: result = (addr & ~mask) | (inc & mask);
      default:    result = addr;
    endcase
    return result;
  endfunction

  function automatic logic [63:0] final_beat_addr(
    input logic [63:0] addr,
    input logic [2:0]  size,
    input logic [7:0]  len,
    input logic [1:0]  burst
  );
    logic [63:0] span;
    logic [63:0] mask;
    logic [63:0] result;
    span = {56'd0, len} << size;
    mask = wrap_mask(size, len);
    case (burst)
      BURST_INCR: result = addr + span;
      BURST_WRAP: result = (addr & ~mask) | ((addr + span) & mask);
      default:    result = addr;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/sram_bytewise.sv
module sram_bytewise #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_BITS  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic [ADDR_BITS-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (we[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read port holds its word until the next read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && (we == '0)) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned MEM_WORDS_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR      = 64'd0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam logic [63:0] MEM_BYTES  = 64'd1 << (MEM_WORDS_LOG2 + ADDR_LSB);

  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES);
  endfunction

  function automatic logic [MEM_WORDS_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return MEM_WORDS_LOG2'((64'(a) - BASE_ADDR) >> ADDR_LSB);
  endfunction

  state_t                  state;
  logic                    prio_w;
  logic                    ready_en;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [7:0]              cnt;
  logic                    err;

  logic                    grant_w;
  logic                    grant_r;
  logic                    aw_hs;
  logic                    ar_hs;
  logic                    w_hs;
  logic                    last_beat;
  logic                    wlast_bad;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [7:0]              req_len;
  logic [2:0]              req_size;
  logic [1:0]              req_burst;
  logic                    req_err;
  logic [ADDR_WIDTH-1:0]   next_addr;

  logic                    mem_en;
  logic [STRB_WIDTH-1:0]   mem_we;
  logic [MEM_WORDS_LOG2-1:0] mem_idx;
  logic [DATA_WIDTH-1:0]   mem_q;

  logic                    unused_sideband;
  assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

  always_comb begin
    grant_w = s_axi_awvalid && (!s_axi_arvalid || prio_w);
    grant_r = s_axi_arvalid && !grant_w;
  end

  assign s_axi_awready = ready_en && (state == IDLE) && grant_w;
  assign s_axi_arready = ready_en && (state == IDLE) && grant_r;
  assign aw_hs         = s_axi_awvalid && s_axi_awready;
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign w_hs          = s_axi_wvalid && s_axi_wready;
  assign last_beat     = (cnt == len_q);
  assign wlast_bad     = (s_axi_wlast != last_beat);
  assign next_addr     = ADDR_WIDTH'(next_beat_addr(64'(addr_q), size_q, len_q, burst_q));

  always_comb begin
    logic [63:0] start_a;
    logic [63:0] final_a;
    req_addr  = grant_w ? s_axi_awaddr  : s_axi_araddr;
    req_len   = grant_w ? s_axi_awlen   : s_axi_arlen;
    req_size  = grant_w ? s_axi_awsize  : s_axi_arsize;
    req_burst = grant_w ? s_axi_awburst : s_axi_arburst;
    start_a   = 64'(req_addr);
    final_a   = final_beat_addr(start_a, req_size, req_len, req_burst);
    req_err   = 1'b0;
    if (req_burst == 2'b11) req_err = 1'b1;
    if (req_size > 3'(ADDR_LSB)) req_err = 1'b1;
    if (req_burst == BURST_WRAP) begin
      if (!(req_len inside {8'd1, 8'd3, 8'd7, 8'd15})) req_err = 1'b1;
      if ((start_a & ((64'd1 << req_size) - 64'd1)) != 64'd0) req_err = 1'b1;
    end
    if (!in_range(start_a) || !in_range(final_a)) req_err = 1'b1;
  end

  // Write gating includes the current beat's wlast mismatch so a bad beat never lands.
  always_comb begin
    mem_en  = 1'b0;
    mem_we  = '0;
    mem_idx = word_idx(addr_q);
    case (state)
      IDLE: begin
        mem_idx = word_idx(req_addr);
        mem_en  = ar_hs && !req_err;
      end
      WBEAT: begin
        if (w_hs && !err && !wlast_bad) begin
          mem_en = 1'b1;
          mem_we = s_axi_wstrb;
        end
      end
      RBEAT: begin
        mem_idx = word_idx(next_addr);
        mem_en  = s_axi_rready && !err && !last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      prio_w   <= 1'b1;
      ready_en <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      cnt      <= '0;
      err      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (aw_hs || ar_hs) begin
            addr_q  <= req_addr;
            len_q   <= req_len;
            size_q  <= req_size;
            burst_q <= req_burst;
            cnt     <= '0;
            err     <= req_err;
            if (s_axi_awvalid && s_axi_arvalid) prio_w <= !prio_w;
            state   <= aw_hs ? WBEAT : RBEAT;
          end
        end
        WBEAT: begin
          if (w_hs) begin
            addr_q <= next_addr;
            cnt    <= cnt + 8'd1;
            if (wlast_bad) err <= 1'b1;
            if (last_beat) state <= WRESP;
          end
        end
        WRESP: begin
          if (s_axi_bready) state <= IDLE;
        end
        RBEAT: begin
          if (s_axi_rready) begin
            addr_q <= next_addr;
            cnt    <= cnt + 8'd1;
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_axi_wready = (state == WBEAT);
  assign s_axi_bvalid = (state == WRESP);
  assign s_axi_bresp  = (s_axi_bvalid && err) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rvalid = (state == RBEAT);
  assign s_axi_rlast  = s_axi_rvalid && last_beat;
  assign s_axi_rresp  = (s_axi_rvalid && err) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rdata  = (s_axi_rvalid && !err) ? mem_q : '0;

  sram_bytewise #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (MEM_WORDS_LOG2)
  ) u_sram (
    .clk   (aclk),
    .rst_n (aresetn),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_idx),
    .wdata (s_axi_wdata),
    .rdata (mem_q)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = '0;
  logic [1:0]  s_axi_awburst = '0;
  logic        s_axi_awlock = 1'b0;
  logic [3:0]  s_axi_awcache = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic [3:0]  s_axi_awqos = '0;
  logic [3:0]  s_axi_awregion = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [63:0] s_axi_wdata = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = '0;
  logic [1:0]  s_axi_arburst = '0;
  logic        s_axi_arlock = 1'b0;
  logic [3:0]  s_axi_arcache = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic [3:0]  s_axi_arqos = '0;
  logic [3:0]  s_axi_arregion = '0;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;

  int checks = 0;
  int errors = 0;

  logic [63:0] pat [4] = '{64'h11, 64'h22, 64'h33, 64'h44};

  always #5 aclk = ~aclk;

  axi_sram_slave #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (64),
    .MEM_WORDS_LOG2 (12),
    .BASE_ADDR      (64'd0)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axi_awvalid  (s_axi_awvalid),
    .s_axi_awready  (s_axi_awready),
    .s_axi_awaddr   (s_axi_awaddr),
    .s_axi_awlen    (s_axi_awlen),
    .s_axi_awsize   (s_axi_awsize),
    .s_axi_awburst  (s_axi_awburst),
    .s_axi_awlock   (s_axi_awlock),
    .s_axi_awcache  (s_axi_awcache),
    .s_axi_awprot   (s_axi_awprot),
    .s_axi_awqos    (s_axi_awqos),
    .s_axi_awregion (s_axi_awregion),
    .s_axi_wvalid   (s_axi_wvalid),
    .s_axi_wready   (s_axi_wready),
    .s_axi_wdata    (s_axi_wdata),
    .s_axi_wstrb    (s_axi_wstrb),
    .s_axi_wlast    (s_axi_wlast),
    .s_axi_bvalid   (s_axi_bvalid),
    .s_axi_bready   (s_axi_bready),
    .s_axi_bresp    (s_axi_bresp),
    .s_axi_arvalid  (s_axi_arvalid),
    .s_axi_arready  (s_axi_arready),
    .s_axi_araddr   (s_axi_araddr),
    .s_axi_arlen    (s_axi_arlen),
    .s_axi_arsize   (s_axi_arsize),
    .s_axi_arburst  (s_axi_arburst),
    .s_axi_arlock   (s_axi_arlock),
    .s_axi_arcache  (s_axi_arcache),
    .s_axi_arprot   (s_axi_arprot),
    .s_axi_arqos    (s_axi_arqos),
    .s_axi_arregion (s_axi_arregion),
    .s_axi_rvalid   (s_axi_rvalid),
    .s_axi_rready   (s_axi_rready),
    .s_axi_rdata    (s_axi_rdata),
    .s_axi_rresp    (s_axi_rresp),
    .s_axi_rlast    (s_axi_rlast)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    s_axi_awaddr  = a;
    s_axi_awlen   = l;
    s_axi_awsize  = s;
    s_axi_awburst = b;
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    s_axi_araddr  = a;
    s_axi_arlen   = l;
    s_axi_arsize  = s;
    s_axi_arburst = b;
  endtask

  task automatic aw_hs(input string tag, input bit keep);
    int n = 0;
    s_axi_awvalid = 1'b1;
    #1;
    while (!s_axi_awready && n < 50) begin tick(); n++; end
    check({tag, ".awready"}, 64'(s_axi_awready), 64'd1);
    @(posedge aclk);
    #1;
    if (!keep) s_axi_awvalid = 1'b0;
  endtask

  task automatic ar_hs(input string tag, input bit keep);
    int n = 0;
    s_axi_arvalid = 1'b1;
    #1;
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    check({tag, ".arready"}, 64'(s_axi_arready), 64'd1);
    @(posedge aclk);
    #1;
    if (!keep) s_axi_arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] strb, input logic last, input string tag);
    int n = 0;
    s_axi_wvalid = 1'b1;
    s_axi_wdata  = d;
    s_axi_wstrb  = strb;
    s_axi_wlast  = last;
    #1;
    while (!s_axi_wready && n < 50) begin tick(); n++; end
    check({tag, ".wready"}, 64'(s_axi_wready), 64'd1);
    @(posedge aclk);
    #1;
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
  endtask

  task automatic b_hs(input logic [1:0] exp, input string tag);
    int n = 0;
    s_axi_bready = 1'b1;
    #1;
    while (!s_axi_bvalid && n < 50) begin tick(); n++; end
    check({tag, ".bvalid"}, 64'(s_axi_bvalid), 64'd1);
    check({tag, ".bresp"}, 64'(s_axi_bresp), 64'(exp));
    @(posedge aclk);
    #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic r_beat(input logic [63:0] d, input logic [1:0] resp, input logic last, input string tag);
    int n = 0;
    s_axi_rready = 1'b1;
    #1;
    while (!s_axi_rvalid && n < 50) begin tick(); n++; end
    check({tag, ".rvalid"}, 64'(s_axi_rvalid), 64'd1);
    check({tag, ".rdata"}, s_axi_rdata, d);
    check({tag, ".rresp"}, 64'(s_axi_rresp), 64'(resp));
    check({tag, ".rlast"}, 64'(s_axi_rlast), 64'(last));
    @(posedge aclk);
    #1;
    s_axi_rready = 1'b0;
  endtask

  initial begin
    // Reset with both address channels already requesting
    set_aw(32'h100, 8'd3, 3'd3, 2'b01);
    set_ar(32'h100, 8'd3, 3'd3, 2'b01);
    s_axi_awvalid = 1'b1;
    s_axi_arvalid = 1'b1;
    tick();
    tick();
    check("rst.awready", 64'(s_axi_awready), 64'd0);
    check("rst.arready", 64'(s_axi_arready), 64'd0);
    check("rst.wready", 64'(s_axi_wready), 64'd0);
    check("rst.bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst.rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst.rlast", 64'(s_axi_rlast), 64'd0);
    check("rst.rdata", s_axi_rdata, 64'd0);
    check("rst.bresp", 64'(s_axi_bresp), 64'd0);
    check("rst.rresp", 64'(s_axi_rresp), 64'd0);
    aresetn = 1'b1;
    #1;
    check("rel.awready_pre_edge", 64'(s_axi_awready), 64'd0);
    tick();
    check("arb1.awready", 64'(s_axi_awready), 64'd1);
    check("arb1.arready", 64'(s_axi_arready), 64'd0);

    // Arbitration 1: write wins; INCR write 0x100 x4
    aw_hs("arb1", 1'b0);
    check("wbeat.arready", 64'(s_axi_arready), 64'd0);
    for (int i = 0; i < 4; i++) w_beat(pat[i], 8'hFF, i == 3, "wr1");
    set_aw(32'h200, 8'd0, 3'd3, 2'b01);
    s_axi_awvalid = 1'b1;
    #1;
    check("wresp.awready", 64'(s_axi_awready), 64'd0);
    b_hs(2'b00, "wr1");

    // Arbitration 2: read wins; readback with latency check
    check("arb2.arready", 64'(s_axi_arready), 64'd1);
    check("arb2.awready", 64'(s_axi_awready), 64'd0);
    ar_hs("arb2", 1'b1);
    check("rd1.first_rvalid", 64'(s_axi_rvalid), 64'd1);
    for (int i = 0; i < 4; i++) r_beat(pat[i], 2'b00, i == 3, "rd1");
    check("rd1.rvalid_end", 64'(s_axi_rvalid), 64'd0);

    // Arbitration 3: write wins again; fill word 0x200 with ones
    check("arb3.awready", 64'(s_axi_awready), 64'd1);
    check("arb3.arready", 64'(s_axi_arready), 64'd0);
    aw_hs("arb3", 1'b0);
    s_axi_arvalid = 1'b0;
    w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, "wr3");
    b_hs(2'b00, "wr3");

    // Partial strobe write and readback
    set_aw(32'h200, 8'd0, 3'd3, 2'b01);
    aw_hs("strb", 1'b0);
    w_beat(64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1'b1, "strb");
    b_hs(2'b00, "strb");
    set_ar(32'h200, 8'd0, 3'd3, 2'b01);
    ar_hs("strb_rd", 1'b0);
    r_beat(64'hFFFF_FFFF_CCCC_DDDD, 2'b00, 1'b1, "strb_rd");

    // WRAP read from 0x118
    set_ar(32'h118, 8'd3, 3'd3, 2'b10);
    ar_hs("wrap", 1'b0);
    r_beat(64'h44, 2'b00, 1'b0, "wrap0");
    r_beat(64'h11, 2'b00, 1'b0, "wrap1");
    r_beat(64'h22, 2'b00, 1'b0, "wrap2");
    r_beat(64'h33, 2'b00, 1'b1, "wrap3");

    // W data ahead of AW stays stalled
    s_axi_wvalid = 1'b1;
    #1;
    check("wstall0.wready", 64'(s_axi_wready), 64'd0);
    tick();
    check("wstall1.wready", 64'(s_axi_wready), 64'd0);
    s_axi_wvalid = 1'b0;

    // Error reads
    set_ar(32'h8000, 8'd1, 3'd3, 2'b01);
    ar_hs("oob", 1'b0);
    r_beat(64'd0, 2'b10, 1'b0, "oob0");
    r_beat(64'd0, 2'b10, 1'b1, "oob1");
    set_ar(32'h100, 8'd1, 3'd3, 2'b11);
    ar_hs("b11", 1'b0);
    r_beat(64'd0, 2'b10, 1'b0, "b11_0");
    r_beat(64'd0, 2'b10, 1'b1, "b11_1");
    set_ar(32'h100, 8'd0, 3'd4, 2'b01);
    ar_hs("wide", 1'b0);
    r_beat(64'd0, 2'b10, 1'b1, "wide0");
    set_ar(32'h100, 8'd2, 3'd3, 2'b10);
    ar_hs("wraplen", 1'b0);
    r_beat(64'd0, 2'b10, 1'b0, "wraplen0");
    r_beat(64'd0, 2'b10, 1'b0, "wraplen1");
    r_beat(64'd0, 2'b10, 1'b1, "wraplen2");

    // Early wlast: both beats consumed, SLVERR, memory untouched
    set_aw(32'h100, 8'd1, 3'd3, 2'b01);
    aw_hs("badlast", 1'b0);
    w_beat(64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 1'b1, "badlast0");
    w_beat(64'hBEEF_BEEF_BEEF_BEEF, 8'hFF, 1'b0, "badlast1");
    b_hs(2'b10, "badlast");
    set_ar(32'h100, 8'd1, 3'd3, 2'b01);
    ar_hs("badlast_rd", 1'b0);
    r_beat(64'h11, 2'b00, 1'b0, "badlast_rd0");
    r_beat(64'h22, 2'b00, 1'b1, "badlast_rd1");

    // Reset mid-read while stalled on beat 2
    set_ar(32'h100, 8'd3, 3'd3, 2'b01);
    ar_hs("mid", 1'b0);
    r_beat(64'h11, 2'b00, 1'b0, "mid0");
    r_beat(64'h22, 2'b00, 1'b0, "mid1");
    check("mid2.rvalid", 64'(s_axi_rvalid), 64'd1);
    check("mid2.rdata", s_axi_rdata, 64'h33);
    tick();
    check("mid2.rdata_held", s_axi_rdata, 64'h33);
    check("mid2.rlast_held", 64'(s_axi_rlast), 64'd0);
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst.rvalid", 64'(s_axi_rvalid), 64'd0);
    check("midrst.rdata", s_axi_rdata, 64'd0);
    tick();
    tick();
    set_ar(32'h108, 8'd0, 3'd3, 2'b01);
    s_axi_arvalid = 1'b1;
    aresetn = 1'b1;
    #1;
    check("midrel.arready_pre_edge", 64'(s_axi_arready), 64'd0);
    ar_hs("post", 1'b0);
    r_beat(64'h22, 2'b00, 1'b1, "post0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- ID-less AXI4 slave that terminates the master port of the AXI ID-stripping stage and services its traffic from an on-chip synchronous word memory.
- Handles one transaction at a time; the upstream stage already serialises traffic and forces all IDs to 0, so this block has no ID ports.
- Supports FIXED, INCR and WRAP bursts, narrow sizes and byte strobes.
- Used as the memory endpoint in block-level simulation and on small FPGA builds.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 64, data width; a power of two, 32..512
MEM_WORDS_LOG2, 12, log2 of memory depth in DATA_WIDTH words
BASE_ADDR, 0, byte address of word 0; must be aligned to the memory size

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
s_axi_awvalid/awready  in/out  1  write address handshake
s_axi_awaddr  in  ADDR_WIDTH  write start byte address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  log2 bytes per beat
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_axi_awlock/awcache/awprot/awqos/awregion  in  1/4/3/4/4  accepted, ignored
s_axi_wvalid/wready  in/out  1  write data handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last beat
s_axi_bvalid/bready  out/in  1  write response handshake
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_arvalid/arready  in/out  1  read address handshake
s_axi_araddr/arlen/arsize/arburst  in  ADDR_WIDTH/8/3/2  as for AW
s_axi_arlock/arcache/arprot/arqos/arregion  in  1/4/3/4/4  accepted, ignored
s_axi_rvalid/rready  out/in  1  read data handshake
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  as bresp
s_axi_rlast  out  1  last read beat

Behaviour:
- Reset, asynchronous on aresetn low: state IDLE; priority flag = write-first. awready, wready, arready, bvalid, rvalid and rlast are 0; bresp, rresp and rdata are 0. Memory contents are not reset.
- All readies are forced to 0 until the first clock edge after aresetn deasserts.
- FSM states: IDLE, WBEAT, WRESP, RBEAT.
- IDLE arbitration:
  - awvalid only: grant write.
  - arvalid only: grant read.
  - Both: grant the side named by the priority flag; the flag then toggles to the other side.
  - awready/arready are asserted combinationally for the granted side only.
  - AW handshake -> WBEAT. AR handshake -> RBEAT.
- On AW or AR accept: latch address, len, size and burst. Set err if any of the following holds:
  - burst = 11;
  - 2^size > DATA_WIDTH/8;
  - WRAP with len not in {1,3,7,15};
  - WRAP with an address not aligned to 2^size;
  - the start or final beat address falls outside [BASE_ADDR, BASE_ADDR + 2^MEM_WORDS_LOG2 * DATA_WIDTH/8).
- Beat address update after each beat:
  - FIXED: unchanged.
  - INCR: addr + 2^size, no 4 KB check.
  - WRAP: low bits wrap within a (len+1) * 2^size aligned window.
  - Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
- WBEAT:
  - wready = 1.
  - Each handshake writes the bytes selected by wstrb into the addressed word, unless err is set.
  - A beat counter counts 0..len. On the beat where count == len -> WRESP, regardless of wlast.
  - wlast high on an earlier beat, or low on the final beat, sets err; the remaining beats are still consumed.
- WRESP: bvalid = 1; bresp = err ? 10 : 00. bvalid is held until bready, then -> IDLE.
- RBEAT:
  - The memory read is issued at the AR handshake edge; rvalid rises 1 cycle later.
  - Each R handshake issues the next beat's read, so throughput is 1 beat/cycle while rready is held high.
  - rdata, rresp and rlast stay stable while rvalid && !rready.
  - rlast = 1 on beat len. The handshake of that beat -> IDLE, with rvalid low next cycle.
  - If err is set: rdata = 0, rresp = 10 on every beat, and the memory is not read.
- Narrow transfers: full words are read and written. The master places the lanes; wstrb is honoured as given.
- No AW/AR is accepted outside IDLE. A wvalid arriving before AW is left stalled (wready = 0).

Decomposition:
- Package axi_pkg holds:
  - BURST_FIXED/INCR/WRAP;
  - RESP_OKAY/SLVERR;
  - the state enum;
  - function next_beat_addr(addr, size, len, burst), shared with the ID-stripping stage's tests.
- One sub-module: sram_bytewise (single-port memory, synchronous read, per-byte write enable, 1-cycle read latency).

Test Plan:
- INCR write, awaddr 0x100, len 3, size 3, wdata 0x11..0x44, wstrb 0xFF -> bresp 00. Then a read with the same parameters -> 4 beats 0x11,0x22,0x33,0x44, rlast on the 4th, rresp 00, first rvalid 1 cycle after the AR handshake.
- WRAP read, araddr 0x118, len 3, size 3 -> addresses 0x118, 0x100, 0x108, 0x110.
- Write with wstrb 0x0F, wdata 0xAAAA_BBBB_CCCC_DDDD over a word holding all-ones -> readback 0xFFFF_FFFF_CCCC_DDDD.
- awvalid and arvalid asserted together for 3 consecutive transactions after reset -> grant order write, read, write.
- Read from an address past the memory end, or with burst 11, len 1 -> 2 beats, rdata 0, rresp 10. Write len 1 with wlast on beat 0 -> 2 beats consumed, bresp 10, memory unchanged.
- Pulse aresetn low mid-RBEAT, beat 2 of 4, with rready held low -> rvalid 0 immediately; after release, the state is IDLE and a new AR is accepted.
